// File: rtl/mul_man_round_pipe_if.sv
// Handshake and data bundle between the FPU_MUL normaliser, the mantissa rounder and the result packer.
// The slave modport is the rounder's view; the master modport is the upstream/downstream environment's view.
interface mul_man_round_pipe_if #(
  parameter int SIZE_MAN = 24,
  parameter int SIZE_EXT = 3,
  parameter int SIZE_EXP = 8
);
  logic                         i_valid;
  logic                         o_ready;
  logic                         i_sign;
  logic [SIZE_EXP-1:0]          i_exp;
  logic [SIZE_MAN+SIZE_EXT-1:0] i_man;
  logic [1:0]                   i_mode;
  logic                         o_valid;
  logic                         i_ready;
  logic                         o_sign;
  logic [SIZE_EXP-1:0]          o_exp;
  logic [SIZE_MAN-1:0]          o_man;
  logic                         o_inexact;
  logic                         o_exp_ovf;

  modport slave (
    input  i_valid, i_sign, i_exp, i_man, i_mode, i_ready,
    output o_ready, o_valid, o_sign, o_exp, o_man, o_inexact, o_exp_ovf
  );

  modport master (
    output i_valid, i_sign, i_exp, i_man, i_mode, i_ready,
    input  o_ready, o_valid, o_sign, o_exp, o_man, o_inexact, o_exp_ovf
  );
endinterface

// File: rtl/mul_man_round_pipe.sv
// Two-stage IEEE-754 mantissa rounder with four rounding modes and exponent renormalisation on carry-out.
// Stage 1 captures the increment decision per beat; stage 2 adds it and saturates the exponent at all-ones.
module mul_man_round_pipe #(
  parameter int SIZE_MAN = 24,
  parameter int SIZE_EXT = 3,
  parameter int SIZE_EXP = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  mul_man_round_pipe_if.slave   bus
);
  localparam int W = SIZE_MAN + SIZE_EXT;

  typedef enum logic [1:0] {
    MODE_RNE = 2'b00,
    MODE_RTZ = 2'b01,
    MODE_RUP = 2'b10,
    MODE_RDN = 2'b11
  } roundMode_e;

  roundMode_e          mode;
  logic                keptLsb;
  logic                guardBit;
  logic                stickyBit;
  logic                s1Inc_d;
  logic                s1Inexact_d;

  logic                s1Valid_q;
  logic                s1Sign_q;
  logic [SIZE_EXP-1:0] s1Exp_q;
  logic [SIZE_MAN-1:0] s1Kept_q;
  logic                s1Inc_q;
  logic                s1Inexact_q;
  logic                s1AllOnes_q;

  logic [SIZE_MAN:0]   sumWide;
  logic                carry;
  logic [SIZE_MAN-1:0] s2Man_d;
  logic [SIZE_EXP-1:0] s2Exp_d;
  logic                s2Ovf_d;

  logic                s2Valid_q;
  logic                s2Sign_q;
  logic [SIZE_EXP-1:0] s2Exp_q;
  logic [SIZE_MAN-1:0] s2Man_q;
  logic                s2Inexact_q;
  logic                s2Ovf_q;

  logic                s1Advance;
  logic                s2Advance;
  logic                accept;

  assign mode = roundMode_e'(bus.i_mode);

  always_comb begin
    keptLsb     = bus.i_man[SIZE_EXT];
    guardBit    = bus.i_man[SIZE_EXT-1];
    stickyBit   = |bus.i_man[SIZE_EXT-2:0];
    s1Inexact_d = guardBit | stickyBit;
    s1Inc_d     = 1'b0;
    case (mode)
      MODE_RNE: s1Inc_d = guardBit & (stickyBit | keptLsb);
      MODE_RTZ: s1Inc_d = 1'b0;
      MODE_RUP: s1Inc_d = s1Inexact_d & ~bus.i_sign;
      MODE_RDN: s1Inc_d = s1Inexact_d & bus.i_sign;
      default:  s1Inc_d = 1'b0;
    endcase
  end

  // A stage may take new data when it is empty or its occupant leaves on the same edge.
  assign s2Advance   = ~s2Valid_q | bus.i_ready;
  assign s1Advance   = ~s1Valid_q | s2Advance;
  assign accept      = bus.i_valid & s1Advance;
  assign bus.o_ready = s1Advance;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1Valid_q   <= 1'b0;
      s1Sign_q    <= 1'b0;
      s1Exp_q     <= '0;
      s1Kept_q    <= '0;
      s1Inc_q     <= 1'b0;
      s1Inexact_q <= 1'b0;
      s1AllOnes_q <= 1'b0;
    end else begin
      if (s1Advance) begin
        s1Valid_q <= accept;
      end
      if (accept) begin
        s1Sign_q    <= bus.i_sign;
        s1Exp_q     <= bus.i_exp;
        s1Kept_q    <= bus.i_man[W-1:SIZE_EXT];
        s1Inc_q     <= s1Inc_d;
        s1Inexact_q <= s1Inexact_d;
        s1AllOnes_q <= &bus.i_man[W-1:SIZE_EXT];
      end
    end
  end

  // On carry the wide sum is exactly 1000..0, so its upper SIZE_MAN bits are the renormalised mantissa.
  always_comb begin
    sumWide = {1'b0, s1Kept_q} + {{SIZE_MAN{1'b0}}, s1Inc_q};
    carry   = s1AllOnes_q & s1Inc_q;
    s2Man_d = carry ? sumWide[SIZE_MAN:1] : sumWide[SIZE_MAN-1:0];
    s2Exp_d = s1Exp_q;
    if (carry && !(&s1Exp_q)) begin
      s2Exp_d = s1Exp_q + {{(SIZE_EXP-1){1'b0}}, 1'b1};
    end
    s2Ovf_d = &s2Exp_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2Valid_q   <= 1'b0;
      s2Sign_q    <= 1'b0;
      s2Exp_q     <= '0;
      s2Man_q     <= '0;
      s2Inexact_q <= 1'b0;
      s2Ovf_q     <= 1'b0;
    end else begin
      if (s2Advance) begin
        s2Valid_q <= s1Valid_q;
      end
      if (s2Advance && s1Valid_q) begin
        s2Sign_q    <= s1Sign_q;
        s2Exp_q     <= s2Exp_d;
        s2Man_q     <= s2Man_d;
        s2Inexact_q <= s1Inexact_q;
        s2Ovf_q     <= s2Ovf_d;
      end
    end
  end

  assign bus.o_valid   = s2Valid_q;
  assign bus.o_sign    = s2Sign_q;
  assign bus.o_exp     = s2Exp_q;
  assign bus.o_man     = s2Man_q;
  assign bus.o_inexact = s2Inexact_q;
  assign bus.o_exp_ovf = s2Ovf_q;

endmodule

// File: tb/tb_mul_man_round_pipe.sv
// Directed and streamed checks of the mantissa rounder: rounding modes, carry renormalisation,
// exponent saturation, backpressure, full throughput and asynchronous reset with beats in flight.
module tb_mul_man_round_pipe;
  localparam int SIZE_MAN = 24;
  localparam int SIZE_EXT = 3;
  localparam int SIZE_EXP = 8;
  localparam logic [1:0] RNE = 2'b00;
  localparam logic [1:0] RTZ = 2'b01;
  localparam logic [1:0] RUP = 2'b10;
  localparam logic [1:0] RDN = 2'b11;

  logic clk;
  logic rst;
  int   testCount = 0;
  int   failCount = 0;

  logic        beatSign [100];
  logic [7:0]  beatExp  [100];
  logic [26:0] beatMan  [100];
  logic [1:0]  beatMode [100];

  mul_man_round_pipe_if #(.SIZE_MAN(SIZE_MAN), .SIZE_EXT(SIZE_EXT), .SIZE_EXP(SIZE_EXP)) bus ();

  mul_man_round_pipe #(.SIZE_MAN(SIZE_MAN), .SIZE_EXT(SIZE_EXT), .SIZE_EXP(SIZE_EXP)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: compare the discarded bits against one half ulp instead of splitting guard/sticky.
  function automatic logic [34:0] model(input logic sign, input logic [7:0] exp,
                                        input logic [26:0] man, input logic [1:0] mode);
    int unsigned kept;
    int unsigned rem;
    int unsigned up;
    int unsigned res;
    logic [7:0]  e;
    kept = {5'b0, man} >> 3;
    rem  = {29'b0, man[2:0]};
    e    = exp;
    case (mode)
      RNE:     up = ((rem > 4) || (rem == 4 && (kept % 2) == 1)) ? 1 : 0;
      RTZ:     up = 0;
      RUP:     up = (rem != 0 && !sign) ? 1 : 0;
      default: up = (rem != 0 && sign) ? 1 : 0;
    endcase
    res = kept + up;
    if (res == 32'h0100_0000) begin
      res = 32'h0080_0000;
      if (e != 8'hFF) e = e + 8'd1;
    end
    return {sign, e, res[23:0], rem != 0, e == 8'hFF};
  endfunction

  // Presents one beat at posedge+1 into an empty pipe and checks it surfaces two edges later.
  task automatic applyStimulus(input logic sign, input logic [7:0] exp, input logic [26:0] man,
                               input logic [1:0] mode, input string tag);
    bus.i_sign  = sign;
    bus.i_exp   = exp;
    bus.i_man   = man;
    bus.i_mode  = mode;
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    checkOutput({tag, "_early"}, 64'(bus.o_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_valid"}, 64'(bus.o_valid), 64'd1);
  endtask

  task automatic checkResult(input string tag, input logic [23:0] man, input logic [7:0] exp,
                             input logic sign, input logic inexact, input logic ovf);
    checkOutput({tag, "_man"},     64'(bus.o_man),     64'(man));
    checkOutput({tag, "_exp"},     64'(bus.o_exp),     64'(exp));
    checkOutput({tag, "_sign"},    64'(bus.o_sign),    64'(sign));
    checkOutput({tag, "_inexact"}, 64'(bus.o_inexact), 64'(inexact));
    checkOutput({tag, "_ovf"},     64'(bus.o_exp_ovf), 64'(ovf));
  endtask

  task automatic runStream(input int n, input bit toggle, input string tag);
    logic [34:0] expQ [$];
    int          accCount  = 0;
    int          emitCount = 0;
    int          inFlight;
    int          cycle     = 0;
    int          firstAcc  = -1;
    int          firstEmit = -1;
    int          lastEmit  = -1;
    bit          acceptedFlag = 1'b0;
    bit          done         = 1'b0;
    bit          stallPrev    = 1'b0;
    logic [35:0] held = '0;
    logic [34:0] outVec;
    logic [34:0] expVec;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fork
      begin : driveBeats
        int idx   = 0;
        int guard = 0;
        while (idx < n && guard < 2000) begin
          bus.i_sign  = beatSign[idx];
          bus.i_exp   = beatExp[idx];
          bus.i_man   = beatMan[idx];
          bus.i_mode  = beatMode[idx];
          bus.i_valid = 1'b1;
          @(posedge clk); #1;
          guard++;
          if (acceptedFlag) idx++;
        end
        bus.i_valid = 1'b0;
      end
      begin : driveReady
        int cyc = 0;
        while (!done) begin
          bus.i_ready = toggle ? (cyc % 3 == 0) : 1'b1;
          @(posedge clk); #1;
          cyc++;
        end
        bus.i_ready = 1'b1;
      end
      begin : monitor
        while (emitCount < n && cycle < 2000) begin
          @(negedge clk);
          cycle++;
          inFlight = accCount - emitCount;
          outVec   = {bus.o_sign, bus.o_exp, bus.o_man, bus.o_inexact, bus.o_exp_ovf};
          if (toggle)
            checkOutput({tag, "_ready_rule"}, 64'(bus.o_ready), 64'(!(inFlight == 2 && !bus.i_ready)));
          if (stallPrev)
            checkOutput({tag, "_stall_hold"}, 64'({bus.o_valid, outVec}), 64'(held));
          acceptedFlag = bus.i_valid && bus.o_ready;
          if (acceptedFlag) begin
            expQ.push_back(model(bus.i_sign, bus.i_exp, bus.i_man, bus.i_mode));
            accCount++;
            if (firstAcc < 0) firstAcc = cycle;
          end
          if (bus.o_valid && bus.i_ready) begin
            if (expQ.size() == 0) begin
              checkOutput({tag, "_unexpected_beat"}, 64'(expQ.size()), 64'd1);
            end else begin
              expVec = expQ.pop_front();
              checkOutput({tag, "_result"}, 64'(outVec), 64'(expVec));
            end
            emitCount++;
            if (firstEmit < 0) firstEmit = cycle;
            lastEmit = cycle;
          end
          stallPrev = bus.o_valid && !bus.i_ready;
          held      = {bus.o_valid, outVec};
        end
        checkOutput({tag, "_count"}, 64'(emitCount), 64'(n));
        done = 1'b1;
      end
    join
    if (!toggle) begin
      checkOutput({tag, "_fill"},       64'(firstEmit - firstAcc), 64'd2);
      checkOutput({tag, "_throughput"}, 64'(lastEmit - firstEmit), 64'(n - 1));
    end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_sign  = 1'b0;
    bus.i_exp   = '0;
    bus.i_man   = '0;
    bus.i_mode  = RNE;
    bus.i_ready = 1'b1;
    rst         = 1'b1;
    #12;
    checkOutput("reset_valid", 64'(bus.o_valid), 64'd0);
    checkOutput("reset_ready", 64'(bus.o_ready), 64'd1);
    checkOutput("reset_man",   64'(bus.o_man),   64'd0);
    checkOutput("reset_exp",   64'(bus.o_exp),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(1'b0, 8'h7F, 27'h000000C, RNE, "rne_up");
    checkResult("rne_up", 24'h000002, 8'h7F, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h7F, 27'h0000014, RNE, "rne_tie");
    checkResult("rne_tie", 24'h000002, 8'h7F, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h7F, 27'h0000014, RTZ, "rtz_tie");
    checkResult("rtz_tie", 24'h000002, 8'h7F, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h7F, 27'h0000014, RUP, "rup_pos");
    checkResult("rup_pos", 24'h000003, 8'h7F, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h7F, 27'h0000014, RDN, "rdn_neg");
    checkResult("rdn_neg", 24'h000003, 8'h7F, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h7F, 27'h0000014, RUP, "rup_neg");
    checkResult("rup_neg", 24'h000002, 8'h7F, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h40, 27'h0000009, RNE, "rne_sticky_only");
    checkResult("rne_sticky_only", 24'h000001, 8'h40, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h40, 27'h0000009, RUP, "rup_sticky_only");
    checkResult("rup_sticky_only", 24'h000002, 8'h40, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h7F, 27'h7FFFFFF, RNE, "carry_7f");
    checkResult("carry_7f", 24'h800000, 8'h80, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'hFE, 27'h7FFFFFF, RNE, "carry_fe");
    checkResult("carry_fe", 24'h800000, 8'hFF, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'hFF, 27'h7FFFFFF, RNE, "carry_ff");
    checkResult("carry_ff", 24'h800000, 8'hFF, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h7F, 27'h7FFFFFF, RTZ, "rtz_no_carry");
    checkResult("rtz_no_carry", 24'hFFFFFF, 8'h7F, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h45, 27'h0000000, RUP, "zero");
    checkResult("zero", 24'h000000, 8'h45, 1'b0, 1'b0, 1'b0);

    beatSign[0] = 1'b0; beatExp[0] = 8'h7F; beatMan[0] = 27'h000000C; beatMode[0] = RNE;
    beatSign[1] = 1'b1; beatExp[1] = 8'h10; beatMan[1] = 27'h7FFFFFF; beatMode[1] = RDN;
    beatSign[2] = 1'b0; beatExp[2] = 8'hFE; beatMan[2] = 27'h7FFFFFC; beatMode[2] = RUP;
    beatSign[3] = 1'b1; beatExp[3] = 8'h01; beatMan[3] = 27'h0000015; beatMode[3] = RTZ;
    beatSign[4] = 1'b0; beatExp[4] = 8'h80; beatMan[4] = 27'h0000000; beatMode[4] = RNE;
    beatSign[5] = 1'b1; beatExp[5] = 8'h33; beatMan[5] = 27'h1234567; beatMode[5] = RUP;
    runStream(6, 1'b1, "backpressure");

    for (int i = 0; i < 100; i++) begin
      beatSign[i] = 1'($urandom);
      beatExp[i]  = (i % 11 == 0) ? 8'hFE : 8'($urandom);
      beatMan[i]  = 27'($urandom);
      if (i % 7 == 0) beatMan[i] = beatMan[i] | 27'h7FFFFF8;
      beatMode[i] = 2'($urandom);
    end
    runStream(100, 1'b0, "throughput");

    // Two beats in flight, then reset lands between clock edges.
    bus.i_ready = 1'b1;
    bus.i_sign  = 1'b0; bus.i_exp = 8'h7F; bus.i_man = 27'h000000C; bus.i_mode = RNE;
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_man   = 27'h7FFFFFF;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid",   64'(bus.o_valid),   64'd0);
    checkOutput("midrst_ready",   64'(bus.o_ready),   64'd1);
    checkOutput("midrst_man",     64'(bus.o_man),     64'd0);
    checkOutput("midrst_exp",     64'(bus.o_exp),     64'd0);
    checkOutput("midrst_inexact", 64'(bus.o_inexact), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("midrst_no_stale", 64'(bus.o_valid), 64'd0);
    end
    applyStimulus(1'b1, 8'h22, 27'h0000014, RDN, "after_rst");
    checkResult("after_rst", 24'h000003, 8'h22, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    checkOutput("after_rst_drained", 64'(bus.o_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
